la_clkmux_ctrl: RTL

LA_CLKMUX_CTRL -- requirements
Module: la_clkmux_ctrl

---
 rtl/la_clkmux_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/la_clkmux_ctrl.sv
// la_clkmux_ctrl: break-before-make sequencer for a glitch-free 2-input clock mux.
// A switch request drops the old select, waits W cycles, raises the new select,
// waits W cycles more, then pulses done. W = max(wait_cycles, 1), latched on acceptance.
// Handshake: req is a level sampled only in IDLE or DONE; there is no ready, a
// request seen while busy is simply dropped and must be re-issued by the requester.
module la_clkmux_ctrl #(
    parameter        PROP = "DEFAULT",
    parameter int    CW   = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          req_sel,
    input  logic [CW-1:0] wait_cycles,
    output logic          sel0,
    output logic          sel1,
    output logic          cur_sel,
    output logic          busy,
    output logic          done,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BREAK = 2'd1,
        ST_MAKE  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;      // cycles left in the current phase, minus one
    logic [CW-1:0] wlat;     // latched W-1, reloaded at MAKE entry
    logic          tgt;      // latched target source
    logic [CW-1:0] w_m1;     // W-1 from the live input, zero counts as one

    // Settle length minus one; a zero request is treated as a one-cycle phase
    always_comb begin
        w_m1 = '0;
        if (wait_cycles != '0) begin
            w_m1 = wait_cycles - CW'(1);
        end
    end

    assign state_dbg = state;

    // Sequencer: all outputs are registered and updated together with the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            sel0    <= 1'b1;
            sel1    <= 1'b0;
            cur_sel <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            wlat    <= '0;
            tgt     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    // DONE behaves exactly like IDLE for a new request
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    if (req) begin
                        if (req_sel != cur_sel) begin
                            state <= ST_BREAK;
                            cnt   <= w_m1;
                            wlat  <= w_m1;
                            tgt   <= req_sel;
                            sel0  <= 1'b0;
                            sel1  <= 1'b0;
                            busy  <= 1'b1;
                        end else begin
                            // Already on the requested source: acknowledge only
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_BREAK: begin
                    if (cnt == '0) begin
                        state   <= ST_MAKE;
                        cnt     <= wlat;
                        sel0    <= ~tgt;
                        sel1    <= tgt;
                        cur_sel <= tgt;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_MAKE: begin
                    if (cnt == '0) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    // Unreachable encodings fall back to the reset picture
                    state   <= ST_IDLE;
                    sel0    <= 1'b1;
                    sel1    <= 1'b0;
                    cur_sel <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    cnt     <= '0;
                    wlat    <= '0;
                    tgt     <= 1'b0;
                end
            endcase
        end
    end

endmodule
